// File: rtl/kyogenrv_dmem_avmm_bridge.sv
// ---------------------------------------------------------------------------
// kyogenrv_dmem_avmm_bridge
//
// Bridges the KyogenRV data-memory request interface onto a pipelined
// Avalon-MM master. Only one transaction is outstanding at a time. Reads wait
// for avm_readdatavalid, so slaves of any latency work. Writes are posted.
// A watchdog aborts any transaction that stays on the bus for TIMEOUT_CYCLES
// cycles and sets a sticky bus_error flag.
//
// Parameters
//   TIMEOUT_CYCLES : bus cycles allowed per transaction (1..65535)
//   ERR_DATA       : read data returned when a read is aborted
//
// Ports
//   clock, reset_n          : clock, asynchronous active-low reset
//   r_dmem_data_req         : CPU read request
//   w_dmem_data_req         : CPU write request (wins over a read)
//   dmem_addr               : byte address
//   w_dmem_data             : write data
//   w_dmem_data_byteenable  : write byte enables
//   r_dmem_data_ack         : one-cycle read-complete pulse
//   r_dmem_data             : last read data, held until the next read completes
//   dmem_waitrequest        : stall toward the CPU
//   avm_*                   : Avalon-MM master (address/read/write/writedata/
//                             byteenable out; waitrequest/readdata/
//                             readdatavalid in)
//   bus_error               : sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module kyogenrv_dmem_avmm_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        r_dmem_data_req,
  input  logic        w_dmem_data_req,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] w_dmem_data,
  input  logic [3:0]  w_dmem_data_byteenable,
  output logic        r_dmem_data_ack,
  output logic [31:0] r_dmem_data,
  output logic        dmem_waitrequest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR_CMD  = 3'd3,
    RESP    = 3'd4
  } state_t;

  // The counter is 0 in the first bus cycle, so the last permitted cycle is
  // TIMEOUT_CYCLES-1.
  localparam logic [15:0] LAST_BUS_CYCLE = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        is_read, is_read_next;
  logic        read_next, write_next, error_next;
  logic [31:0] address_next, writedata_next, rdata_next;
  logic [3:0]  byteenable_next;
  logic        timed_out;

  assign timed_out        = (cnt == LAST_BUS_CYCLE);
  assign dmem_waitrequest = (r_dmem_data_req | w_dmem_data_req) & (state != RESP);
  assign r_dmem_data_ack  = (state == RESP) & is_read;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      is_read        <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      r_dmem_data    <= '0;
      bus_error      <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      is_read        <= is_read_next;
      avm_read       <= read_next;
      avm_write      <= write_next;
      avm_address    <= address_next;
      avm_writedata  <= writedata_next;
      avm_byteenable <= byteenable_next;
      r_dmem_data    <= rdata_next;
      bus_error      <= error_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold-value default first, so no
    // path through the case statement can infer a latch.
    state_next      = state;
    cnt_next        = cnt;
    is_read_next    = is_read;
    read_next       = avm_read;
    write_next      = avm_write;
    address_next    = avm_address;
    writedata_next  = avm_writedata;
    byteenable_next = avm_byteenable;
    rdata_next      = r_dmem_data;
    error_next      = bus_error;

    case (state)
      IDLE: begin
        if (w_dmem_data_req) begin
          state_next      = WR_CMD;
          cnt_next        = '0;
          is_read_next    = 1'b0;
          write_next      = 1'b1;
          address_next    = dmem_addr;
          writedata_next  = w_dmem_data;
          byteenable_next = w_dmem_data_byteenable;
        end else if (r_dmem_data_req) begin
          state_next      = RD_CMD;
          cnt_next        = '0;
          is_read_next    = 1'b1;
          read_next       = 1'b1;
          address_next    = dmem_addr;
          byteenable_next = 4'hF;
        end
      end

      RD_CMD: begin
        cnt_next = cnt + 16'd1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          // Zero-latency slave: data arrives with the accepted command.
          read_next  = 1'b0;
          rdata_next = avm_readdata;
          state_next = RESP;
        end else if (timed_out) begin
          read_next  = 1'b0;
          rdata_next = ERR_DATA;
          error_next = 1'b1;
          state_next = RESP;
        end else if (!avm_waitrequest) begin
          read_next  = 1'b0;
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        cnt_next = cnt + 16'd1;
        if (avm_readdatavalid) begin
          rdata_next = avm_readdata;
          state_next = RESP;
        end else if (timed_out) begin
          rdata_next = ERR_DATA;
          error_next = 1'b1;
          state_next = RESP;
        end
      end

      WR_CMD: begin
        cnt_next = cnt + 16'd1;
        if (!avm_waitrequest) begin
          write_next = 1'b0;
          state_next = RESP;
        end else if (timed_out) begin
          write_next = 1'b0;
          error_next = 1'b1;
          state_next = RESP;
        end
      end

      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/kyogenrv_dmem_avmm_bridge.md
# kyogenrv_dmem_avmm_bridge

Data-memory bus bridge that sits directly downstream of the KyogenRV Avalon-MM CPU wrapper. It consumes the wrapper's data-memory request signals (read/write request, address, write data, byte enables). It drives a pipelined Avalon-MM master port toward the system interconnect. It returns read data, a read acknowledge and the `dmem_waitrequest` stall the wrapper folds into the core's wait-request. It allows one outstanding transaction, supports variable-latency slaves through `avm_readdatavalid`, and has a bus-timeout watchdog.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles a transaction may spend in a bus state before it is aborted; range 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an aborted read.
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `r_dmem_data_req` input 1: CPU read request.
- `w_dmem_data_req` input 1: CPU write request.
- `dmem_addr` input 32: byte address.
- `w_dmem_data` input 32: write data.
- `w_dmem_data_byteenable` input 4: write byte enables.
- `r_dmem_data_ack` output 1: one-cycle read-data-valid pulse to the CPU.
- `r_dmem_data` output 32: read data; holds its value until the next read completes.
- `dmem_waitrequest` output 1: stall toward the CPU.
- `avm_address` output 32: Avalon-MM address.
- `avm_read` output 1: Avalon-MM read.
- `avm_write` output 1: Avalon-MM write.
- `avm_writedata` output 32: Avalon-MM write data.
- `avm_byteenable` output 4: Avalon-MM byte enables.
- `avm_waitrequest` input 1: slave stall.
- `avm_readdata` input 32: slave read data.
- `avm_readdatavalid` input 1: slave read-data valid.
- `bus_error` output 1: sticky flag, set on any timeout.

## Operation
- FSM states are IDLE, RD_CMD, RD_WAIT, WR_CMD and RESP.
- IDLE:
  - On `w_dmem_data_req`, latch address, data and byte enables, then go to WR_CMD.
  - Otherwise, on `r_dmem_data_req`, latch the address and force byte enables to 4'hF, then go to RD_CMD.
  - Write has priority when both requests are high; the read request is serviced after the write completes, if it is still held.
- RD_CMD:
  - `avm_read`=1.
  - When `avm_waitrequest`=0, go to RD_WAIT.
  - If `avm_readdatavalid`=1 in the same cycle (zero-latency slave), capture `avm_readdata` and go directly to RESP.
- RD_WAIT:
  - `avm_read`=0.
  - On `avm_readdatavalid`, capture `avm_readdata` into `r_dmem_data` and go to RESP.
- WR_CMD:
  - `avm_write`=1.
  - When `avm_waitrequest`=0, go to RESP. Writes are posted; there is no response phase.
- RESP:
  - One cycle only. `dmem_waitrequest`=0.
  - `r_dmem_data_ack`=1 if the transaction was a read.
  - Return to IDLE.
- `avm_read`, `avm_write`, `avm_address`, `avm_writedata` and `avm_byteenable` are registered. Address and data stay stable for the whole command phase.
- `dmem_waitrequest` is combinational: `(r_dmem_data_req | w_dmem_data_req) & (state != RESP)`.
- Timeout counter (16 bits):
  - Clears on entry to RD_CMD or WR_CMD and increments in RD_CMD, RD_WAIT and WR_CMD.
  - On reaching `TIMEOUT_CYCLES`, deassert `avm_read`/`avm_write`, set `bus_error`, load `ERR_DATA` into `r_dmem_data` on a read, and go to RESP.
- `avm_readdatavalid` arriving in IDLE or WR_CMD (late data after an abort) is ignored and does not change `r_dmem_data`.
- `bus_error` clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - State is IDLE.
  - All outputs are 0, including `r_dmem_data`=32'h0 and `bus_error`=0.
  - `dmem_waitrequest` follows its equation, so it is high if a request is already present.
- Reset asserted mid-transaction drops `avm_read`/`avm_write` immediately. The slave's in-flight response is discarded.
- Read latency with `avm_waitrequest`=0 and `avm_readdatavalid` one cycle after acceptance:
  - Request seen at cycle 0 in IDLE.
  - Command at cycle 1.
  - Data captured at cycle 2.
  - Ack at cycle 3.
  - Each wait-state adds one cycle.
- Write latency with `avm_waitrequest`=0: request at cycle 0, command at cycle 1, RESP at cycle 2.
- A request still present in the cycle after RESP is treated as a new transaction. The CPU must drop its request in the cycle that it sees `dmem_waitrequest`=0.
- Throughput is at most one read per 4 cycles and one write per 3 cycles.

## Test plan
- Read from 0x0000_0010:
  - Slave uses 0 wait-states and returns 32'h1234_5678 one cycle after acceptance.
  - `avm_read` is high for exactly 1 cycle.
  - `r_dmem_data_ack` pulses at cycle 3 with `r_dmem_data`=32'h1234_5678.
- Write 32'hCAFE_F00D with byte enables 4'b0011 to 0x0000_0020:
  - Slave asserts `avm_waitrequest` for 3 cycles.
  - `avm_write` is high for 4 cycles with address, data and byte enables stable.
  - `dmem_waitrequest` drops at cycle 5.
- Simultaneous read and write requests:
  - The write is issued first.
  - The read is issued in the cycle after RESP.
  - `r_dmem_data_ack` pulses only for the read.
- Timeout with `TIMEOUT_CYCLES`=8 and `avm_waitrequest` held high:
  - `avm_read` drops after 8 cycles.
  - `r_dmem_data`=32'hDEAD_BEEF with an ack pulse, and `bus_error`=1.
  - A late `avm_readdatavalid` is ignored.
- `reset_n` pulsed low during RD_WAIT:
  - All outputs are 0 asynchronously.
  - After release, a fresh read completes normally.
